// File: rtl/dcache_miss_ctrl_if.sv
// dcache_miss_ctrl_if: miss-request, memory-bus, fill and writeback signals of the dcache miss controller
//   master: the controller; slave: pipeline, memory bus and data array around it
interface dcache_miss_ctrl_if #(parameter int TAG_W = 4) ();
  logic [1:0]        miss_valid;
  logic [1:0][31:0]  miss_addr;
  logic              miss_stall;
  logic [1:0]        proc2mem_command;
  logic [31:0]       proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [63:0]       mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;
  logic              wr2_en;
  logic [4:0]        wr2_idx;
  logic [7:0]        wr2_tag;
  logic [63:0]       wr2_data;
  logic [7:0]        wr2_usebytes;
  logic              wr2_dirty;
  logic              need_write_mem;
  logic [63:0]       wb_mem_data;
  logic [31:0]       wb_mem_addr;
  logic              fill_valid;
  logic [31:0]       fill_addr;
  modport master (
    input  miss_valid, miss_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
           need_write_mem, wb_mem_data, wb_mem_addr,
    output miss_stall, proc2mem_command, proc2mem_addr, proc2mem_data, wr2_en, wr2_idx,
           wr2_tag, wr2_data, wr2_usebytes, wr2_dirty, fill_valid, fill_addr
  );
  modport slave (
    output miss_valid, miss_addr, mem2proc_response, mem2proc_data, mem2proc_tag,
           need_write_mem, wb_mem_data, wb_mem_addr,
    input  miss_stall, proc2mem_command, proc2mem_addr, proc2mem_data, wr2_en, wr2_idx,
           wr2_tag, wr2_data, wr2_usebytes, wr2_dirty, fill_valid, fill_addr
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: miss-status controller tracking DEPTH outstanding load-miss blocks for the dcache
//   clock, reset_n : clock and synchronous active-low reset
//   bus (master)   : miss requests/stall, memory command/response/tag, array fill (wr2_*), dirty eviction (wb_*)
//   DCACHE_MISS_MERGE_EN: when defined, misses to a block already tracked (or port 0's same-cycle block) allocate nothing
module dcache_miss_ctrl #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input logic                clock,
  input logic                reset_n,
  dcache_miss_ctrl_if.master bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {INVALID, PEND, INFL, READY} ent_t;
  ent_t             r_state [DEPTH];
  ent_t             w_state_nxt [DEPTH];
  logic [28:0]      r_blk [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [IW-1:0]    r_q [DEPTH];
  logic [IW-1:0]    r_head;
  logic [IW:0]      r_cnt;
  logic             r_wb_v;
  logic [63:0]      r_wb_data;
  logic [28:0]      r_wb_blk;
  logic             r_stall;
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_cap;
  logic             w_hit0, w_hit1, w_alloc0, w_alloc1;
  logic [IW-1:0]    w_idx0, w_idx1, w_fidx, w_head_idx, w_tail;
  logic             w_fill, w_ld_acc, w_st_acc;
  logic [IW:0]      w_nfree;
  logic [28:0]      w_fblk;
  logic             w_unused;
  assign w_unused   = ^{bus.miss_addr[0][2:0], bus.miss_addr[1][2:0], bus.wb_mem_addr[2:0]};
  assign w_head_idx = r_q[r_head];
  assign w_tail     = r_head + r_cnt[IW-1:0];
  assign w_ld_acc   = !r_wb_v && r_cnt != '0 && bus.mem2proc_response != '0;
  assign w_st_acc   = r_wb_v && bus.mem2proc_response != '0;
  // allocation: port 0 takes the lowest free entry, port 1 the lowest one left
  always_comb begin
    w_free = '0;
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    w_idx0 = '0;
    w_idx1 = '0;
    for (int i = 0; i < DEPTH; i++) w_free[i] = r_state[i] == INVALID;
`ifdef DCACHE_MISS_MERGE_EN
    for (int i = 0; i < DEPTH; i++) begin
      w_hit0 = w_hit0 | (!w_free[i] && r_blk[i] == bus.miss_addr[0][31:3]);
      w_hit1 = w_hit1 | (!w_free[i] && r_blk[i] == bus.miss_addr[1][31:3]);
    end
    w_hit1 = w_hit1 | (bus.miss_valid[0] && bus.miss_addr[0][31:3] == bus.miss_addr[1][31:3]);
`endif
    w_alloc0 = bus.miss_valid[0] && !w_hit0;
    w_alloc1 = bus.miss_valid[1] && !w_hit1;
    for (int i = DEPTH - 1; i >= 0; i--) if (w_free[i]) w_idx0 = IW'(i);
    for (int i = DEPTH - 1; i >= 0; i--) if (w_free[i] && !(w_alloc0 && IW'(i) == w_idx0)) w_idx1 = IW'(i);
  end
  // fills stall while an eviction waits so the single wb buffer cannot overflow
  always_comb begin
    w_fill = 1'b0;
    w_fidx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (r_state[i] == READY) begin
      w_fill = !r_wb_v;
      w_fidx = IW'(i);
    end
    w_fblk = r_blk[w_fidx];
  end
  always_comb begin
    w_cap   = '0;
    w_nfree = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cap[i] = r_state[i] == INFL && bus.mem2proc_tag != '0 && r_tag[i] == bus.mem2proc_tag;
      if (w_alloc0 && w_idx0 == IW'(i)) w_state_nxt[i] = PEND;
      if (w_alloc1 && w_idx1 == IW'(i)) w_state_nxt[i] = PEND;
      if (w_ld_acc && w_head_idx == IW'(i)) w_state_nxt[i] = INFL;
      if (w_cap[i]) w_state_nxt[i] = READY;
      if (w_fill && w_fidx == IW'(i)) w_state_nxt[i] = INVALID;
      w_nfree = w_nfree + (IW+1)'(w_state_nxt[i] == INVALID);
    end
  end
  always_comb begin
    bus.proc2mem_command = r_wb_v ? 2'd2 : r_cnt != '0 ? 2'd1 : 2'd0;
    bus.proc2mem_addr    = r_wb_v ? {r_wb_blk, 3'b0} : r_cnt != '0 ? {r_blk[w_head_idx], 3'b0} : 32'h0;
    bus.proc2mem_data    = r_wb_v ? r_wb_data : 64'h0;
    bus.wr2_en           = w_fill;
    bus.wr2_idx          = w_fill ? w_fblk[4:0] : 5'h0;
    bus.wr2_tag          = w_fill ? w_fblk[12:5] : 8'h0;
    bus.wr2_data         = w_fill ? r_data[w_fidx] : 64'h0;
    bus.wr2_usebytes     = w_fill ? 8'hFF : 8'h00;
    bus.wr2_dirty        = 1'b0;
    bus.fill_valid       = w_fill;
    bus.fill_addr        = w_fill ? {w_fblk, 3'b0} : 32'h0;
    bus.miss_stall       = r_stall;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= INVALID;
      r_head  <= '0;
      r_cnt   <= '0;
      r_wb_v  <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= w_state_nxt[i];
      r_head  <= r_head + IW'(w_ld_acc);
      r_cnt   <= r_cnt + (IW+1)'(w_alloc0) + (IW+1)'(w_alloc1) - (IW+1)'(w_ld_acc);
      r_wb_v  <= (r_wb_v && !w_st_acc) || (w_fill && bus.need_write_mem);
      r_stall <= w_nfree < (IW+1)'(2);
    end
  end
  // issue order queue: entry indices in allocation order, head is the oldest PEND entry
  always_ff @(posedge clock) begin
    if (w_alloc0) r_blk[w_idx0] <= bus.miss_addr[0][31:3];
    if (w_alloc1) r_blk[w_idx1] <= bus.miss_addr[1][31:3];
    if (w_alloc0) r_q[w_tail] <= w_idx0;
    if (w_alloc1) r_q[w_tail + IW'(w_alloc0)] <= w_idx1;
    if (w_ld_acc) r_tag[w_head_idx] <= bus.mem2proc_response;
    for (int i = 0; i < DEPTH; i++) if (w_cap[i]) r_data[i] <= bus.mem2proc_data;
    if (w_fill && bus.need_write_mem) begin
      r_wb_data <= bus.wb_mem_data;
      r_wb_blk  <= bus.wb_mem_addr[31:3];
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;
`ifdef DCACHE_MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  dcache_miss_ctrl_if #(.TAG_W(4)) bus ();
  dcache_miss_ctrl #(.DEPTH(8), .TAG_W(4)) dut (.clock(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic miss(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    bus.miss_valid = v;
    bus.miss_addr[0] = a0;
    bus.miss_addr[1] = a1;
    step();
    bus.miss_valid = 2'b00;
  endtask
  task automatic resp(input logic [3:0] t);
    bus.mem2proc_response = t;
    step();
    bus.mem2proc_response = 4'h0;
  endtask
  task automatic tagd(input logic [3:0] t, input logic [63:0] d);
    bus.mem2proc_tag = t;
    bus.mem2proc_data = d;
    step();
    bus.mem2proc_tag = 4'h0;
  endtask
  always @(negedge clk) if (rst_n && bus.miss_valid != 2'b00) chk("alloc_while_stall", 64'(bus.miss_stall), 64'h0);
  initial begin
    bus.miss_valid = 2'b00;
    bus.miss_addr = '0;
    bus.mem2proc_response = 4'h0;
    bus.mem2proc_data = 64'h0;
    bus.mem2proc_tag = 4'h0;
    bus.need_write_mem = 1'b0;
    bus.wb_mem_data = 64'h0;
    bus.wb_mem_addr = 32'h0;
    step();
    step();
    chk("rst_cmd", 64'(bus.proc2mem_command), 64'h0);
    chk("rst_stall", 64'(bus.miss_stall), 64'h0);
    chk("rst_wr2_en", 64'(bus.wr2_en), 64'h0);
    chk("rst_fill_valid", 64'(bus.fill_valid), 64'h0);
    chk("rst_addr", 64'(bus.proc2mem_addr), 64'h0);
    rst_n = 1'b1;
    step();
    // basic miss -> load -> response -> tag -> fill
    miss(2'b01, 32'h1008, 32'h0);
    chk("t1_cmd", 64'(bus.proc2mem_command), 64'h1);
    chk("t1_addr", 64'(bus.proc2mem_addr), 64'h1008);
    resp(4'h3);
    chk("t1_cmd_idle", 64'(bus.proc2mem_command), 64'h0);
    step();
    bus.mem2proc_tag = 4'h3;
    bus.mem2proc_data = 64'hD1D1_0000_1111_2222;
    chk("t1_no_early_fill", 64'(bus.wr2_en), 64'h0);
    step();
    bus.mem2proc_tag = 4'h0;
    chk("t1_wr2_en", 64'(bus.wr2_en), 64'h1);
    chk("t1_idx", 64'(bus.wr2_idx), 64'h1);
    chk("t1_tag", 64'(bus.wr2_tag), 64'h10);
    chk("t1_data", bus.wr2_data, 64'hD1D1_0000_1111_2222);
    chk("t1_use", 64'(bus.wr2_usebytes), 64'hFF);
    chk("t1_dirty", 64'(bus.wr2_dirty), 64'h0);
    chk("t1_fvalid", 64'(bus.fill_valid), 64'h1);
    chk("t1_faddr", 64'(bus.fill_addr), 64'h1008);
    step();
    chk("t1_done", 64'(bus.wr2_en), 64'h0);
    chk("t1_use0", 64'(bus.wr2_usebytes), 64'h0);
    // retry while response stays 0
    miss(2'b01, 32'h1008, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("t2_cmd", 64'(bus.proc2mem_command), 64'h1);
      chk("t2_addr", 64'(bus.proc2mem_addr), 64'h1008);
      if (k < 4) step();
    end
    chk("t2_nofill", 64'(bus.wr2_en), 64'h0);
    resp(4'h5);
    // writeback priority and fill blocking
    miss(2'b01, 32'h4008, 32'h0);
    resp(4'h6);
    miss(2'b01, 32'h5010, 32'h0);
    chk("t3_pend", 64'(bus.proc2mem_addr), 64'h5010);
    tagd(4'h5, 64'hD2D2_D2D2_0000_0005);
    chk("t3_fill0", 64'(bus.wr2_en), 64'h1);
    chk("t3_fill0_addr", 64'(bus.fill_addr), 64'h1008);
    bus.need_write_mem = 1'b1;
    bus.wb_mem_addr = 32'h2008;
    bus.wb_mem_data = 64'hBEEF_CAFE_1234_5678;
    tagd(4'h6, 64'hD3D3_D3D3_0000_0006);
    bus.need_write_mem = 1'b0;
    chk("t3_store_cmd", 64'(bus.proc2mem_command), 64'h2);
    chk("t3_store_addr", 64'(bus.proc2mem_addr), 64'h2008);
    chk("t3_store_data", bus.proc2mem_data, 64'hBEEF_CAFE_1234_5678);
    chk("t3_blocked", 64'(bus.wr2_en), 64'h0);
    step();
    chk("t3_store_retry", 64'(bus.proc2mem_command), 64'h2);
    chk("t3_blocked2", 64'(bus.wr2_en), 64'h0);
    resp(4'h1);
    chk("t3_fill1", 64'(bus.wr2_en), 64'h1);
    chk("t3_fill1_addr", 64'(bus.fill_addr), 64'h4008);
    chk("t3_fill1_data", bus.wr2_data, 64'hD3D3_D3D3_0000_0006);
    chk("t3_load_cmd", 64'(bus.proc2mem_command), 64'h1);
    chk("t3_load_addr", 64'(bus.proc2mem_addr), 64'h5010);
    chk("t3_load_data", bus.proc2mem_data, 64'h0);
    step();
    resp(4'h7);
    tagd(4'h7, 64'hD4D4_0000_0000_0007);
    chk("t3_fill2_idx", 64'(bus.wr2_idx), 64'h2);
    chk("t3_fill2_tag", 64'(bus.wr2_tag), 64'h50);
    step();
    // both ports miss the same block
    miss(2'b11, 32'h3010, 32'h3010);
    chk("t4_cmd", 64'(bus.proc2mem_command), 64'h1);
    chk("t4_addr", 64'(bus.proc2mem_addr), 64'h3010);
    resp(4'h8);
    chk("t4_second_load", 64'(bus.proc2mem_command), MERGE ? 64'h0 : 64'h1);
    resp(4'h9);
    chk("t4_idle", 64'(bus.proc2mem_command), 64'h0);
    tagd(4'h8, 64'hD5D5_0000_0000_0008);
    chk("t4_fill_a", 64'(bus.wr2_en), 64'h1);
    chk("t4_fill_a_addr", 64'(bus.fill_addr), 64'h3010);
    step();
    tagd(4'h9, 64'hD6D6_0000_0000_0009);
    chk("t4_fill_b", 64'(bus.wr2_en), MERGE ? 64'h0 : 64'h1);
    chk("t4_fill_b_data", bus.wr2_data, MERGE ? 64'h0 : 64'hD6D6_0000_0000_0009);
    step();
    chk("t4_done", 64'(bus.wr2_en), 64'h0);
    // stall threshold
    miss(2'b11, 32'h0001_0000, 32'h0001_0100);
    chk("t5_stall_6free", 64'(bus.miss_stall), 64'h0);
    miss(2'b11, 32'h0001_0200, 32'h0001_0300);
    chk("t5_stall_4free", 64'(bus.miss_stall), 64'h0);
    miss(2'b11, 32'h0001_0400, 32'h0001_0500);
    chk("t5_stall_2free", 64'(bus.miss_stall), 64'h0);
    miss(2'b01, 32'h0001_0600, 32'h0);
    chk("t5_stall_1free", 64'(bus.miss_stall), 64'h1);
    chk("t5_head", 64'(bus.proc2mem_addr), 64'h0001_0000);
    resp(4'h1);
    chk("t5_stall_infl", 64'(bus.miss_stall), 64'h1);
    tagd(4'h1, 64'hD7D7_0000_0000_0001);
    chk("t5_fill", 64'(bus.wr2_en), 64'h1);
    chk("t5_fill_addr", 64'(bus.fill_addr), 64'h0001_0000);
    chk("t5_stall_fill", 64'(bus.miss_stall), 64'h1);
    step();
    chk("t5_stall_freed", 64'(bus.miss_stall), 64'h0);
    // reset with in-flight entries
    chk("t6_head", 64'(bus.proc2mem_addr), 64'h0001_0100);
    resp(4'h2);
    resp(4'h3);
    resp(4'h4);
    chk("t6_next", 64'(bus.proc2mem_addr), 64'h0001_0400);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_cmd", 64'(bus.proc2mem_command), 64'h0);
    chk("t6_rst_stall", 64'(bus.miss_stall), 64'h0);
    for (int t = 2; t <= 4; t++) begin
      tagd(4'(t), 64'hDEAD_0000_0000_0000);
      chk("t6_no_fill", 64'(bus.wr2_en), 64'h0);
      chk("t6_no_cmd", 64'(bus.proc2mem_command), 64'h0);
      chk("t6_no_stall", 64'(bus.miss_stall), 64'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
